pipe_skid_buffer: RTL and testbench
===================================

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the payload width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-005 SHALL have port in_valid, input, 1, upstream offers in_data.
REQ-006 SHALL have port in_ready, output, 1, block can accept this cycle.
REQ-007 SHALL have port in_data, input, WIDTH, upstream payload.
REQ-008 SHALL have port out_valid, output, 1, out_data holds a valid entry.
REQ-009 SHALL have port out_ready, input, 1, downstream consumes this cycle.
REQ-010 SHALL have port out_data, output, WIDTH, oldest held entry.
REQ-011 SHALL have port occupancy, output, 2, number of held entries (0..2).

Function
REQ-012 SHALL hold at most two entries: main register (drives out_data) and skid register.
REQ-013 SHALL have three states: EMPTY (0 entries), BUSY (main only), FULL (main + skid).
REQ-014 Handshake rule: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
REQ-015 in_ready SHALL be (state != FULL), decoded from registered state only, with no combinational path from out_ready.
REQ-016 out_valid SHALL be (state != EMPTY); occupancy SHALL be 0/1/2 for EMPTY/BUSY/FULL.
REQ-017 EMPTY + input transfer SHALL load main with in_data and go to BUSY; out_valid is asserted the cycle after acceptance (latency 1).
REQ-018 BUSY + input and output transfer SHALL load main with in_data and stay BUSY.
REQ-019 BUSY + input transfer only SHALL load skid with in_data and go to FULL; main is unchanged.
REQ-020 BUSY + output transfer only SHALL go to EMPTY.
REQ-021 FULL + output transfer SHALL copy skid into main and go to BUSY.
REQ-022 No transfer SHALL leave state and both data registers unchanged.
REQ-023 While out_valid=1 and out_ready=0, out_data SHALL stay stable until consumed or flushed.
REQ-024 Entries SHALL leave in acceptance order; there is no loss or duplication except by flush.
REQ-025 Sustained in_valid=out_ready=1 SHALL give one transfer per cycle after the first fill cycle.
REQ-026 flush SHALL take priority over all transfers: next state EMPTY.
REQ-027 In a flush cycle, an input accepted per REQ-014 SHALL be discarded.
REQ-028 In a flush cycle, out_valid/out_data SHALL still reflect the current state, so a same-cycle output transfer counts as consumed.
REQ-029 Any unreachable state encoding SHALL transition to EMPTY on the next edge.

Reset
REQ-030 reset=1 at a rising edge SHALL force EMPTY: out_valid=0, occupancy=0, in_ready=1 on the following cycle.
REQ-031 reset SHALL override flush and all transfers; entries held at reset, including mid-operation, are lost.
REQ-032 The main and skid data registers are not reset; out_data is don't-care while out_valid=0.

Structure
REQ-033 The state typedef (EMPTY/BUSY/FULL) SHALL live in the shared pipeline package for reuse by stall/hazard logic.
REQ-034 Main and skid SHALL each be an openhw_flopen instance, with enables from the state logic; no other sub-module.
REQ-035 The state register SHALL be one sequential process with synchronous reset; next-state and enable decode SHALL be combinational.

Verification (WIDTH=8)
REQ-036 Reset, then in_valid=1 in_data=0x3C with out_ready=0 -> next cycle out_valid=1, out_data=0x3C, occupancy=1, in_ready=1.
REQ-037 With out_ready=0, accept 0x11 then 0x22 -> occupancy=2, in_ready=0; 0x33 held on in_data is not accepted; out_ready=1 for two cycles -> out_data 0x11 then 0x22, then out_valid=0.
REQ-038 Stream 0x01..0x10 with in_valid=out_ready=1 every cycle -> 16 outputs in order on consecutive cycles, occupancy never 2.
REQ-039 Start FULL (0xAA, 0xBB) and assert flush with out_ready=1 -> 0xAA counted consumed, next cycle occupancy=0, out_valid=0; 0xBB never appears.
REQ-040 Assert reset while FULL with in_valid=1 -> next cycle occupancy=0, in_ready=1, out_valid=0; the input offered during reset never appears.
REQ-041 Random in_valid/out_ready for 10k cycles vs. a reference queue model -> order, no loss, stall stability (REQ-023) and in_ready independent of same-cycle out_ready all hold.

Source files
------------

// File: rtl/pipe_skid_buffer_pkg.sv
// Shared pipeline definitions: skid-buffer occupancy states and their decode.
// Stall/hazard logic elsewhere imports these so every stage agrees on the encoding.
package pipe_skid_buffer_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  // Encoding 2'd3 is unreachable and reports as empty.
  function automatic logic [1:0] state_occupancy(input skid_state_t st);
    case (st)
      ST_BUSY: state_occupancy = 2'd1;
      ST_FULL: state_occupancy = 2'd2;
      default: state_occupancy = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/openhw_flopen.sv
// Plain enable flop with no reset; holds its value whenever en_i is low.
module openhw_flopen #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer: main register drives out_data, skid register catches the
// entry accepted while downstream stalls, so in_ready depends only on registered state.
module pipe_skid_buffer
  import pipe_skid_buffer_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [1:0]       state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high.
  // in_ready/out_valid are decoded from state_q only; producers never wait on ready.
  skid_state_t      state_q, state_d;
  logic             in_xfer, out_xfer;
  logic             main_en, skid_en, main_from_skid;
  logic [WIDTH-1:0] main_d, main_q, skid_q;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign occupancy = state_occupancy(state_q);
  assign state_dbg = state_q;
  assign out_data  = main_q;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    skid_en        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_en = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (in_xfer && out_xfer) begin
          main_en = 1'b1;
        end else if (in_xfer) begin
          skid_en = 1'b1;
          state_d = ST_FULL;
        end else if (out_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (out_xfer) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_BUSY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over every transfer; an input accepted this cycle is simply dropped.
    if (flush) begin
      state_d = ST_EMPTY;
      main_en = 1'b0;
      skid_en = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  openhw_flopen #(.WIDTH(WIDTH)) u_main (
    .clk_i (clk),
    .en_i  (main_en),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  openhw_flopen #(.WIDTH(WIDTH)) u_skid (
    .clk_i (clk),
    .en_i  (skid_en),
    .d_i   (in_data),
    .q_o   (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Directed and reference-queue checks for pipe_skid_buffer (WIDTH=8).
module tb_pipe_skid_buffer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid;
  logic [W-1:0] in_data, out_data;
  logic [1:0]   occupancy, state_dbg;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  pipe_skid_buffer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: push one entry with downstream stalled
  task automatic push(input logic [W-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("drain_empty", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic         r_iv, r_or, ir_a, prev_stall;
    logic [W-1:0] r_d, prev_data;
    int           ready_model;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_occ",       {30'd0, occupancy}, 32'd0);
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // single accept, latency 1
    in_valid = 1'b1; in_data = 8'h3C;
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check("t1_out_data",  {24'd0, out_data},  32'h3C);
    check("t1_occ",       {30'd0, occupancy}, 32'd1);
    check("t1_in_ready",  {31'd0, in_ready},  32'd1);
    drain();

    // fill to FULL, 0x33 must be refused, then drain in order
    push(8'h11);
    push(8'h22);
    check("t2_occ2",     {30'd0, occupancy}, 32'd2);
    check("t2_in_ready", {31'd0, in_ready},  32'd0);
    in_valid = 1'b1; in_data = 8'h33;
    tick();
    check("t2_refused_occ",  {30'd0, occupancy}, 32'd2);
    check("t2_stall_data",   {24'd0, out_data},  32'h11);
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("t2_ready_indep", {31'd0, in_ready}, 32'd0);
    tick();
    check("t2_second",     {24'd0, out_data},  32'h22);
    check("t2_occ1",       {30'd0, occupancy}, 32'd1);
    tick();
    check("t2_empty",      {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // streaming 0x01..0x10, one per cycle
    out_ready = 1'b1;
    for (int c = 0; c <= 16; c++) begin
      if (c < 16) begin
        in_valid = 1'b1;
        in_data  = 8'(c + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c >= 1) begin
        check("t3_valid", {31'd0, out_valid}, 32'd1);
        check("t3_data",  {24'd0, out_data},  32'(c));
      end
      check("t3_not_full", {31'd0, (occupancy == 2'd2)}, 32'd0);
      tick();
    end
    check("t3_done", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // flush while FULL with out_ready high: 0xAA consumed, 0xBB dropped
    push(8'hAA);
    push(8'hBB);
    flush = 1'b1; out_ready = 1'b1;
    #1;
    check("t4_head", {24'd0, out_data}, 32'hAA);
    tick();
    flush = 1'b0; out_ready = 1'b0;
    check("t4_occ",   {30'd0, occupancy}, 32'd0);
    check("t4_valid", {31'd0, out_valid}, 32'd0);
    push(8'hCC);
    check("t4_next", {24'd0, out_data}, 32'hCC);
    drain();

    // flush drops an input accepted in the same cycle
    in_valid = 1'b1; in_data = 8'h5A; flush = 1'b1;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    check("t4b_dropped", {30'd0, occupancy}, 32'd0);

    // reset while FULL with input offered
    push(8'h44);
    push(8'h55);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h66;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("t5_occ",      {30'd0, occupancy}, 32'd0);
    check("t5_in_ready", {31'd0, in_ready},  32'd1);
    check("t5_valid",    {31'd0, out_valid}, 32'd0);
    // reset while BUSY, where the offered input would otherwise be accepted
    push(8'h77);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h88;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    check("t5b_occ", {30'd0, occupancy}, 32'd0);
    push(8'h99);
    check("t5_after", {24'd0, out_data}, 32'h99);
    drain();

    // random traffic against a reference queue
    exp_q.delete();
    prev_stall = 1'b0;
    prev_data  = '0;
    for (int n = 0; n < 10000; n++) begin
      r_iv = ($urandom_range(0, 99) < 60);
      r_or = ($urandom_range(0, 99) < 50);
      r_d  = 8'($urandom_range(0, 255));
      in_valid = r_iv; in_data = r_d; out_ready = ~r_or;
      #1;
      ir_a = in_ready;
      out_ready = r_or;
      #1;
      check("rnd_ready_indep", {31'd0, in_ready}, {31'd0, ir_a});
      ready_model = (exp_q.size() < 2) ? 1 : 0;
      check("rnd_in_ready",  {31'd0, in_ready},  32'(ready_model));
      check("rnd_out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
      check("rnd_occ",       {30'd0, occupancy}, 32'(exp_q.size()));
      if (exp_q.size() != 0) begin
        check("rnd_data", {24'd0, out_data}, {24'd0, exp_q[0]});
      end
      if (prev_stall) begin
        check("rnd_stable", {24'd0, out_data}, {24'd0, prev_data});
      end
      prev_stall = (exp_q.size() != 0) && !r_or;
      prev_data  = out_data;
      if (exp_q.size() != 0 && r_or) void'(exp_q.pop_front());
      if (r_iv && ready_model == 1) exp_q.push_back(r_d);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
